// File: rtl/engine_pair_scheduler_if.sv
// Stream and datapath signal bundle between engine_pair_scheduler and its neighbours.
// master is the host/datapath side, slave is the scheduler side.
interface engine_pair_scheduler_if;
   logic        w_valid;
   logic        w_ready;
   logic [71:0] w_data;
   logic        d_valid;
   logic        d_ready;
   logic [63:0] d_data;
   logic [63:0] in_data;
   logic [2:0]  addr_in;
   logic        we_in;
   logic [71:0] wi0;
   logic [71:0] wi1;
   logic        en;
   logic        v_flag_io;
   logic [15:0] outa;
   logic [15:0] outb;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;

   modport master (
      output w_valid, w_data, d_valid, d_data, v_flag_io, outa, outb, res_ready,
      input  w_ready, d_ready, in_data, addr_in, we_in, wi0, wi1, en, res_valid, res_data
   );

   modport slave (
      input  w_valid, w_data, d_valid, d_data, v_flag_io, outa, outb, res_ready,
      output w_ready, d_ready, in_data, addr_in, we_in, wi0, wi1, en, res_valid, res_data
   );
endinterface

// File: rtl/engine_pair_scheduler.sv
// Tile sequencer for the two-engine convolution datapath: weights, input rows, run, drain.
// Optional SCHED_PERF_CNT_EN adds a saturating busy-cycle counter on perf_cycles.
module engine_pair_scheduler #(
   parameter int unsigned NUM_ROWS     = 8,
   parameter int unsigned TILE_OUTPUTS = 4,
   parameter int unsigned TIMEOUT      = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic busy,
   output logic done,
   output logic err_timeout,
   output logic overflow,
`ifdef SCHED_PERF_CNT_EN
   output logic [15:0] perf_cycles,
`endif
   engine_pair_scheduler_if.slave bus
);

   typedef enum logic [2:0] {StIdle, StLoadW, StLoadIn, StRun, StDone, StErr} state_e;

   state_e      state_q, state_d;
   logic        beat_q;
   logic [3:0]  row_q;
   logic [7:0]  out_cnt_q;
   logic [7:0]  idle_q;
   logic [71:0] wi0_q, wi1_q;
   logic [63:0] in_data_q;
   logic [2:0]  addr_q;
   logic        we_q;
   logic        res_valid_q;
   logic [31:0] res_data_q;
   logic        err_q;
   logic        ovf_q;

   logic start_ok, w_hs, d_hs, drain, stall, run_en, capture, drop;
   logic timeout_hit, last_row, last_out;

   always_comb begin
      start_ok    = start && (state_q == StIdle || state_q == StErr);
      w_hs        = bus.w_valid && (state_q == StLoadW);
      d_hs        = bus.d_valid && (state_q == StLoadIn);
      drain       = res_valid_q && bus.res_ready;
      stall       = res_valid_q && !bus.res_ready;
      run_en      = (state_q == StRun) && !stall;
      capture     = (state_q == StRun) && bus.v_flag_io && !stall;
      drop        = (state_q == StRun) && bus.v_flag_io && stall;
      timeout_hit = run_en && !bus.v_flag_io && (idle_q == 8'(TIMEOUT - 1));
      last_row    = (row_q == 4'(NUM_ROWS - 1));
      last_out    = (out_cnt_q == 8'(TILE_OUTPUTS - 1));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StErr: if (start) state_d = StLoadW;
         StLoadW:       if (w_hs && beat_q) state_d = StLoadIn;
         StLoadIn:      if (d_hs && last_row) state_d = StRun;
         StRun: begin
            if (timeout_hit)            state_d = StErr;
            else if (capture && last_out) state_d = StDone;
         end
         StDone:        if (!res_valid_q || bus.res_ready) state_d = StIdle;
         default:       state_d = StIdle;
      endcase
   end

   always_comb begin
      busy        = 1'b0;
      done        = 1'b0;
      bus.w_ready = 1'b0;
      bus.d_ready = 1'b0;
      bus.en      = 1'b0;
      unique case (state_q)
         StLoadW: begin
            busy        = 1'b1;
            bus.w_ready = 1'b1;
         end
         StLoadIn: begin
            busy        = 1'b1;
            bus.d_ready = 1'b1;
         end
         StRun: begin
            busy   = 1'b1;
            bus.en = !stall;
         end
         StDone: begin
            busy = 1'b1;
            done = !res_valid_q || bus.res_ready;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         beat_q      <= 1'b0;
         row_q       <= '0;
         out_cnt_q   <= '0;
         idle_q      <= '0;
         wi0_q       <= '0;
         wi1_q       <= '0;
         in_data_q   <= '0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         err_q       <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         we_q <= d_hs;
         if (start_ok) begin
            beat_q    <= 1'b0;
            row_q     <= '0;
            out_cnt_q <= '0;
            idle_q    <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
         end
         if (w_hs) begin
            if (!beat_q) wi0_q <= bus.w_data;
            else         wi1_q <= bus.w_data;
            beat_q <= ~beat_q;
         end
         if (d_hs) begin
            in_data_q <= bus.d_data;
            addr_q    <= row_q[2:0];
            row_q     <= row_q + 4'd1;
         end
         // Idle cycles only count while the engines are actually enabled.
         if (state_q == StRun) begin
            if (bus.v_flag_io) idle_q <= '0;
            else if (run_en)   idle_q <= idle_q + 8'd1;
         end
         if (timeout_hit) err_q <= 1'b1;
         if (drop)        ovf_q <= 1'b1;
         if (capture) begin
            res_data_q  <= {bus.outa, bus.outb};
            res_valid_q <= 1'b1;
            out_cnt_q   <= out_cnt_q + 8'd1;
         end else if (drain || timeout_hit || state_q == StErr) begin
            res_valid_q <= 1'b0;
         end
      end
   end

`ifdef SCHED_PERF_CNT_EN
   logic [15:0] perf_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_q <= '0;
      end else if (start_ok) begin
         perf_q <= '0;
      end else if (busy && perf_q != 16'hFFFF) begin
         perf_q <= perf_q + 16'd1;
      end
   end

   assign perf_cycles = perf_q;
`endif

   assign err_timeout   = err_q;
   assign overflow      = ovf_q;
   assign bus.wi0       = wi0_q;
   assign bus.wi1       = wi1_q;
   assign bus.in_data   = in_data_q;
   assign bus.addr_in   = addr_q;
   assign bus.we_in     = we_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_engine_pair_scheduler.sv
// Self-checking bench for engine_pair_scheduler: randomized tiles against a transaction-level model.
`timescale 1ns/1ps
module tb_engine_pair_scheduler;
   localparam int unsigned NUM_ROWS = 8;
   localparam int unsigned TILE     = 4;
   localparam int unsigned TMO      = 10;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic busy, done, err_timeout, overflow;
`ifdef SCHED_PERF_CNT_EN
   logic [15:0] perf_cycles;
`endif

   engine_pair_scheduler_if bus ();

   engine_pair_scheduler #(
      .NUM_ROWS     (NUM_ROWS),
      .TILE_OUTPUTS (TILE),
      .TIMEOUT      (TMO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .err_timeout (err_timeout),
      .overflow    (overflow),
`ifdef SCHED_PERF_CNT_EN
      .perf_cycles (perf_cycles),
`endif
      .bus         (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [71:0] exp_wi0, exp_wi1;
   logic        pend_we;
   logic [2:0]  pend_addr;
   logic [63:0] pend_data;
   int cyc_w, cyc_in, cyc_run, cyc_done;

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, err_timeout, overflow, bus.w_ready, bus.d_ready, bus.we_in, bus.en,
           bus.res_valid} !== 9'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b want 0", {busy, done, err_timeout, overflow,
                  bus.w_ready, bus.d_ready, bus.we_in, bus.en, bus.res_valid});
      end
      checks++;
      if ({bus.wi0, bus.wi1, bus.in_data, bus.addr_in, bus.res_data} !== '0) begin
         errors++;
         $display("FAIL reset_data: wi0=%h wi1=%h in=%h addr=%h res=%h want all 0",
                  bus.wi0, bus.wi1, bus.in_data, bus.addr_in, bus.res_data);
      end
`ifdef SCHED_PERF_CNT_EN
      checks++;
      if (perf_cycles !== 16'h0) begin
         errors++;
         $display("FAIL reset_perf: got %h want 0", perf_cycles);
      end
`endif
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic start_tile();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc_w = 0; cyc_in = 0; cyc_run = 0; cyc_done = 0;
   endtask

   task automatic load_weights(input logic [71:0] w0, input logic [71:0] w1, input int gap_pct);
      int beats = 0;
      int cyc = 0;
      exp_wi0 = w0;
      exp_wi1 = w1;
      while (beats < 2 && cyc < 200) begin
         @(negedge clk);
         bus.w_valid = ($urandom_range(0, 99) >= gap_pct);
         bus.w_data  = (beats == 0) ? w0 : w1;
         #1;
         if (cyc == 0) begin
            checks++;
            if ({busy, err_timeout, overflow} !== 3'b100) begin
               errors++;
               $display("FAIL tile_start: busy/err/ovf got %b want 100",
                        {busy, err_timeout, overflow});
            end
         end
         checks++;
         if (bus.w_ready !== 1'b1) begin
            errors++;
            $display("FAIL w_ready_high: got %b want 1", bus.w_ready);
         end
         if (bus.w_valid) beats++;
         cyc++;
         cyc_w++;
      end
      if (beats < 2) begin
         checks++; errors++;
         $display("FAIL weight_bound: %0d beats accepted, want 2", beats);
      end
   endtask

   // mode 0: random d_valid, 1: every other cycle with data 1..N, 2: always valid
   task automatic load_rows(input int mode, input int count);
      int rows = 0;
      int cyc = 0;
      pend_we = 1'b0;
      while (rows < count && cyc < 400) begin
         @(negedge clk);
         bus.w_valid = 1'b0;
         case (mode)
            0:       bus.d_valid = 1'($urandom_range(0, 1));
            1:       bus.d_valid = (cyc % 2 == 0);
            default: bus.d_valid = 1'b1;
         endcase
         bus.d_data = (mode == 1) ? 64'(rows + 1) : {$urandom(), $urandom()};
         #1;
         if (cyc == 0) begin
            checks++;
            if (bus.w_ready !== 1'b0 || bus.wi0 !== exp_wi0 || bus.wi1 !== exp_wi1) begin
               errors++;
               $display("FAIL weights: w_ready=%b wi0=%h wi1=%h want 0 %h %h",
                        bus.w_ready, bus.wi0, bus.wi1, exp_wi0, exp_wi1);
            end
         end
         checks++;
         if (bus.d_ready !== 1'b1) begin
            errors++;
            $display("FAIL d_ready_high: got %b want 1", bus.d_ready);
         end
         checks++;
         if (bus.we_in !== pend_we || (pend_we &&
             (bus.addr_in !== pend_addr || bus.in_data !== pend_data))) begin
            errors++;
            $display("FAIL row_write: we=%b addr=%0d data=%h want %b %0d %h",
                     bus.we_in, bus.addr_in, bus.in_data, pend_we, pend_addr, pend_data);
         end
         if (bus.d_valid) begin
            pend_we   = 1'b1;
            pend_addr = 3'(rows);
            pend_data = bus.d_data;
            rows++;
         end else begin
            pend_we = 1'b0;
         end
         cyc++;
         cyc_in++;
      end
      if (rows < count) begin
         checks++; errors++;
         $display("FAIL row_bound: %0d rows accepted, want %0d", rows, count);
      end
   endtask

   // mode 0: random, 1: steady pulses, 2: scripted backpressure, 3: no results (timeout)
   task automatic run_results(input int mode);
      logic        slot_full = 1'b0;
      logic [31:0] slot_val = '0;
      logic        ovf_m = 1'b0;
      logic        v, rdy, exp_en, exp_done, drain, cap;
      logic [15:0] a, b;
      int outs = 0, seen = 0, idle = 0, c = 0;
      int ph = 1;  // 1 run, 2 done, 0 finished, 3 timed out
      while ((ph == 1 || ph == 2) && c < 3000) begin
         @(negedge clk);
         bus.d_valid = 1'b0;
         case (mode)
            0: begin
               v = 1'($urandom_range(0, 1));
               rdy = ($urandom_range(0, 99) < 70);
               a = 16'($urandom());
               b = 16'($urandom());
               start = ($urandom_range(0, 9) == 0);
            end
            1: begin
               v = (c % 2 == 1); rdy = 1'b1; a = 16'h0010; b = 16'h0020;
            end
            2: begin
               rdy = !(c >= 2 && c <= 7);
               v = (c == 1 || c == 4 || c == 6 || (c >= 9 && c % 2 == 1));
               a = 16'(c); b = 16'(c * 3 + 1);
            end
            default: begin
               v = 1'b0; rdy = 1'b1; a = '0; b = '0;
            end
         endcase
         if (ph != 1) v = 1'b0;
         bus.v_flag_io = v;
         bus.res_ready = rdy;
         bus.outa = a;
         bus.outb = b;
         #1;
         exp_en   = (ph == 1) && !(slot_full && !rdy);
         exp_done = (ph == 2) && (!slot_full || rdy);
         checks++;
         if (bus.en !== exp_en || done !== exp_done || busy !== 1'b1 || bus.d_ready !== 1'b0) begin
            errors++;
            $display("FAIL run_ctrl c=%0d: en=%b done=%b busy=%b d_ready=%b want %b %b 1 0",
                     c, bus.en, done, busy, bus.d_ready, exp_en, exp_done);
         end
         checks++;
         if (bus.res_valid !== slot_full || (slot_full && bus.res_data !== slot_val)) begin
            errors++;
            $display("FAIL result c=%0d: valid=%b data=%h want %b %h",
                     c, bus.res_valid, bus.res_data, slot_full, slot_val);
         end
         checks++;
         if (overflow !== ovf_m) begin
            errors++;
            $display("FAIL overflow c=%0d: got %b want %b", c, overflow, ovf_m);
         end
         checks++;
         if (bus.we_in !== pend_we || (pend_we &&
             (bus.addr_in !== pend_addr || bus.in_data !== pend_data))) begin
            errors++;
            $display("FAIL last_row_write: we=%b addr=%0d data=%h want %b %0d %h",
                     bus.we_in, bus.addr_in, bus.in_data, pend_we, pend_addr, pend_data);
         end
         pend_we = 1'b0;
         drain = slot_full && rdy;
         if (drain) seen++;
         if (ph == 1) begin
            cyc_run++;
            cap = v && (!slot_full || rdy);
            if (v && !cap) ovf_m = 1'b1;
            if (v) idle = 0;
            else if (exp_en) idle++;
            if (cap) begin
               slot_full = 1'b1;
               slot_val = {a, b};
               outs++;
            end else if (drain) begin
               slot_full = 1'b0;
            end
            if (idle == TMO) begin
               ph = 3;
               slot_full = 1'b0;
            end else if (outs == TILE) begin
               ph = 2;
            end
         end else begin
            cyc_done++;
            if (drain) slot_full = 1'b0;
            if (exp_done) ph = 0;
         end
         c++;
      end
      if (ph == 1 || ph == 2) begin
         checks++; errors++;
         $display("FAIL run_bound: tile still active after %0d cycles", c);
      end
      @(negedge clk);
      bus.v_flag_io = 1'b0;
      bus.res_ready = 1'b0;
      start = 1'b0;
      #1;
      checks++;
      if ({busy, bus.en, bus.res_valid, done} !== 4'b0) begin
         errors++;
         $display("FAIL tile_end: busy/en/valid/done got %b want 0000",
                  {busy, bus.en, bus.res_valid, done});
      end
      checks++;
      if (err_timeout !== (ph == 3) || overflow !== ovf_m) begin
         errors++;
         $display("FAIL sticky_flags: err=%b ovf=%b want %b %b", err_timeout, overflow,
                  (ph == 3), ovf_m);
      end
      if (ph == 0) begin
         checks++;
         if (seen !== TILE) begin
            errors++;
            $display("FAIL result_count: got %0d want %0d", seen, TILE);
         end
      end
   endtask

   task automatic test_basic_tile();
      start_tile();
      load_weights(72'h01_0000_0001_0000_0001, 72'hFF_FFFF_FFFF_FFFF_FFFF, 0);
      load_rows(1, NUM_ROWS);
      run_results(1);
   endtask

   task automatic test_backpressure();
      start_tile();
      load_weights({8'h3C, $urandom(), $urandom()}, {8'hC3, $urandom(), $urandom()}, 30);
      load_rows(0, NUM_ROWS);
      run_results(2);
   endtask

   task automatic test_timeout();
      start_tile();
      load_weights({8'h11, $urandom(), $urandom()}, {8'h22, $urandom(), $urandom()}, 0);
      load_rows(2, NUM_ROWS);
      run_results(3);
      start_tile();
      load_weights({8'h33, $urandom(), $urandom()}, {8'h44, $urandom(), $urandom()}, 50);
      load_rows(2, NUM_ROWS);
      run_results(1);
   endtask

   task automatic test_random_tiles();
      for (int t = 0; t < 4; t++) begin
         start_tile();
         load_weights({8'(t), $urandom(), $urandom()}, {$urandom(), $urandom(), 8'(t)}, 40);
         load_rows(0, NUM_ROWS);
         run_results(0);
      end
   endtask

   task automatic test_reset_mid_tile();
      start_tile();
      load_weights({8'hA5, $urandom(), $urandom()}, {8'h5A, $urandom(), $urandom()}, 0);
      load_rows(2, 3);
      @(negedge clk);
      bus.d_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({busy, done, err_timeout, overflow, bus.w_ready, bus.d_ready, bus.we_in, bus.en,
           bus.res_valid} !== 9'b0) begin
         errors++;
         $display("FAIL midreset_flags: got %b want 0", {busy, done, err_timeout, overflow,
                  bus.w_ready, bus.d_ready, bus.we_in, bus.en, bus.res_valid});
      end
      checks++;
      if ({bus.wi0, bus.wi1, bus.in_data, bus.addr_in, bus.res_data} !== '0) begin
         errors++;
         $display("FAIL midreset_data: wi0=%h wi1=%h in=%h addr=%h want all 0",
                  bus.wi0, bus.wi1, bus.in_data, bus.addr_in);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: done=%b busy=%b want 0 0", done, busy);
         end
      end
   endtask

`ifdef SCHED_PERF_CNT_EN
   task automatic test_perf();
      int exp_cycles;
      start_tile();
      load_weights({$urandom(), $urandom(), 8'h77}, {$urandom(), $urandom(), 8'h88}, 0);
      load_rows(2, NUM_ROWS);
      run_results(1);
      exp_cycles = cyc_w + cyc_in + cyc_run + cyc_done;
      checks++;
      if (perf_cycles !== 16'(exp_cycles)) begin
         errors++;
         $display("FAIL perf_cycles: got %0d want %0d", perf_cycles, exp_cycles);
      end
   endtask
`endif

   initial begin
      bus.w_valid = 1'b0;
      bus.w_data = '0;
      bus.d_valid = 1'b0;
      bus.d_data = '0;
      bus.v_flag_io = 1'b0;
      bus.outa = '0;
      bus.outb = '0;
      bus.res_ready = 1'b0;
      pend_we = 1'b0;
      pend_addr = '0;
      pend_data = '0;
      test_reset();
      test_basic_tile();
      test_backpressure();
      test_timeout();
      test_random_tiles();
      test_reset_mid_tile();
`ifdef SCHED_PERF_CNT_EN
      test_perf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/engine_pair_scheduler.md
Name: engine_pair_scheduler

Overview:
- Sequences one convolution tile through the two-engine datapath (shared input buffer, two 3x3 engines, summed outputs).
- Per tile: loads the two 72-bit weight sets, writes the input-buffer rows, enables the engines, and collects summed results into a ready/valid stream.
- Sits between the host-side streams and the datapath top.

Parameters:
- NUM_ROWS, 8: input-buffer rows written per tile (1..8; addr_in is 3 bits).
- TILE_OUTPUTS, 4: results collected per tile (1..255).
- TIMEOUT, 255: max RUN cycles with en=1 and no v_flag_io before abort (1..255).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- start  in  1  begin a tile; sampled only in IDLE or ERR
- busy  out  1  high in every state except IDLE and ERR
- done  out  1  one-cycle pulse at tile completion
- err_timeout  out  1  sticky timeout error; cleared by start or reset
- w_valid  in  1  weight beat valid
- w_ready  out  1  weight beat accepted
- w_data  in  72  weight beat
- d_valid  in  1  input row valid
- d_ready  out  1  input row accepted
- d_data  in  64  input row
- in_data  out  64  row data to datapath
- addr_in  out  3  buffer write address
- we_in  out  1  buffer write enable
- wi0  out  72  engine-0 weights, registered
- wi1  out  72  engine-1 weights, registered
- en  out  1  engine enable
- v_flag_io  in  1  datapath result valid
- outa  in  16  datapath summed output A
- outb  in  16  datapath summed output B
- res_valid  out  1  result valid
- res_ready  in  1  result accepted
- res_data  out  32  {outa,outb}, outa in [31:16]
- overflow  out  1  sticky: result lost; cleared by start or reset

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE. All outputs 0, including wi0, wi1, in_data and all counters.
- Reset mid-tile aborts immediately; no done pulse.
- FSM states: IDLE, LOAD_W, LOAD_IN, RUN, DONE, ERR.
- IDLE/ERR, start=1: go to LOAD_W. Clear err_timeout, overflow, beat counter and output counter. Previously loaded wi0/wi1 values are held until overwritten.
- LOAD_W:
  - w_ready=1.
  - First handshake (w_valid & w_ready) registers w_data into wi0; second into wi1.
  - After the second beat go to LOAD_IN.
- LOAD_IN:
  - d_ready=1.
  - Each handshake produces we_in=1 on the next cycle, with in_data=d_data and addr_in=row index 0..NUM_ROWS-1. Output is registered, 1-cycle latency.
  - After the NUM_ROWS-th accept go to RUN; that last write completes in RUN's first cycle.
  - we_in=0 whenever no handshake occurred in the previous cycle.
- RUN:
  - en=1 unless res_valid=1 and res_ready=0 (stall).
  - A capture occurs on a cycle where v_flag_io=1 and either res_valid=0 or res_ready=1. Capture: res_data<={outa,outb}, res_valid<=1, output count +1.
  - v_flag_io=1 while the result slot is full and not draining: result dropped, overflow<=1.
  - Idle counter: +1 on each cycle with en=1 and v_flag_io=0; reset on any v_flag_io=1. When it reaches TIMEOUT: err_timeout<=1, go to ERR.
  - When output count reaches TILE_OUTPUTS, go to DONE.
- DONE:
  - Stay until the last result drains (res_valid=0 or res_ready=1).
  - Then pulse done for one cycle and go to IDLE.
- ERR: en=0, res_valid cleared, busy=0. Leave only via start.
- res_valid falls the cycle after a handshake unless a new capture happens in the same cycle.
- start while busy: ignored.
- Stream readys are 0 outside their own state.

Optional Feature:
- SCHED_PERF_CNT_EN defined:
  - Adds output perf_cycles[15:0].
  - Counts cycles from LOAD_W entry to the done pulse, inclusive; saturates at 16'hFFFF.
  - Cleared on start; holds after done; reset 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Weights: reset, start, w beats 72'h01_0000_0001_0000_0001 then 72'hFF_FFFF_FFFF_FFFF_FFFF -> wi0 and wi1 hold these values; w_ready drops after the 2nd beat.
- Rows: 8 d beats 64'h1..64'h8 with d_valid toggling every other cycle -> we_in pulses with addr_in 0..7 and matching data, one cycle after each accept.
- Results: RUN with v_flag_io pulses carrying outa=16'h0010, outb=16'h0020, res_ready=1 -> 4 results 32'h0010_0020, then done pulse, busy=0.
- Backpressure: res_ready=0 after 1st result -> en=0, res_data held; v_flag_io=1 during stall -> overflow=1; release res_ready -> tile completes.
- Timeout: TIMEOUT=10, no v_flag_io -> err_timeout=1 after 10 en cycles, state ERR; next start clears it.
- Reset mid-tile: rst=0 in LOAD_IN after 3 rows -> all outputs 0 next cycle, no done pulse.
- With SCHED_PERF_CNT_EN, zero-stall tile -> perf_cycles = 2 + 8 + RUN cycles + DONE cycles, exact.
